// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-stage controller: prioritised next-PC selection,
// IF/ID PC/valid register with squash on redirect, and a circular return-address stack.
module pc_fetch_unit #(
    parameter int              ADDR_W     = 8,
    parameter int              STEP       = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = 8'hF0,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic [ADDR_W-1:0] return_addr,
    input  logic              ret,
    input  logic              trap,
    output logic [ADDR_W-1:0] instruction_address,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras_mem;
    logic [PTR_W-1:0]                 top_ptr, ptr_nxt, wr_idx;
    logic [CNT_W-1:0]                 ras_cnt, cnt_nxt;
    logic                             ras_wr, underflow_nxt, redirect;
    logic [ADDR_W-1:0]                pc_nxt, ras_top;
    logic                             cnt_zero, cnt_full;

    assign ras_top  = ras_mem[top_ptr];
    assign cnt_zero = (ras_cnt == '0);
    assign cnt_full = (ras_cnt == CNT_MAX);

    // Next-PC selection, highest priority first; reset is applied in the register.
    always_comb begin
        pc_nxt   = instruction_address + ADDR_W'(STEP);
        redirect = 1'b0;
        if (trap) begin
            pc_nxt   = TRAP_ADDR;
            redirect = 1'b1;
        end else if (ret) begin
            pc_nxt   = cnt_zero ? TRAP_ADDR : ras_top;
            redirect = 1'b1;
        end else if (call || jump) begin
            pc_nxt   = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            pc_nxt   = branch_target;
            redirect = 1'b1;
        end else if (stall) begin
            pc_nxt   = instruction_address;
        end
    end

    // Stack update; a trap in the same cycle suppresses any call/ret effect.
    always_comb begin
        ptr_nxt       = top_ptr;
        cnt_nxt       = ras_cnt;
        wr_idx        = top_ptr;
        ras_wr        = 1'b0;
        underflow_nxt = 1'b0;
        if (!trap) begin
            unique case ({call, ret})
                2'b10: begin
                    ptr_nxt = top_ptr + PTR_ONE;
                    wr_idx  = top_ptr + PTR_ONE;
                    ras_wr  = 1'b1;
                    cnt_nxt = cnt_full ? ras_cnt : ras_cnt + CNT_ONE;
                end
                2'b01: begin
                    if (cnt_zero) begin
                        underflow_nxt = 1'b1;
                    end else begin
                        ptr_nxt = top_ptr - PTR_ONE;
                        cnt_nxt = ras_cnt - CNT_ONE;
                    end
                end
                2'b11: begin
                    ras_wr = 1'b1;
                    if (cnt_zero) begin
                        ptr_nxt       = top_ptr + PTR_ONE;
                        wr_idx        = top_ptr + PTR_ONE;
                        cnt_nxt       = CNT_ONE;
                        underflow_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_address <= RESET_ADDR;
            if_id_pc            <= RESET_ADDR;
            if_id_valid         <= 1'b0;
            top_ptr             <= '0;
            ras_cnt             <= '0;
            ras_empty           <= 1'b1;
            ras_full            <= 1'b0;
            ras_underflow       <= 1'b0;
        end else begin
            instruction_address <= pc_nxt;
            if (redirect) begin
                if_id_pc    <= instruction_address;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_pc    <= instruction_address;
                if_id_valid <= 1'b1;
            end
            if (ras_wr) ras_mem[wr_idx] <= return_addr;
            top_ptr       <= ptr_nxt;
            ras_cnt       <= cnt_nxt;
            ras_empty     <= (cnt_nxt == '0);
            ras_full      <= (cnt_nxt == CNT_MAX);
            ras_underflow <= underflow_nxt;
        end
    end
endmodule
